// File: rtl/ysyx_22050078_mdu_seq.sv
// Multi-cycle RV64M sequencer: radix-2 shift-add multiply / shift-subtract divide on one 128-bit register.
// Optional macro MDU_ZERO_SKIP_EN: multiplies with a zero operand finish straight from accept.
module ysyx_22050078_mdu_seq #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_valid,
  output logic            o_in_ready,
  input  logic [3:0]      i_op,
  input  logic [XLEN-1:0] i_src1,
  input  logic [XLEN-1:0] i_src2,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_out_ready,
  output logic [XLEN-1:0] o_res,
  output logic            o_busy
);

  localparam int HALF = XLEN / 2;
  localparam int CW   = $clog2(XLEN) + 1;

  localparam logic [3:0] OP_MUL    = 4'd0;
  localparam logic [3:0] OP_MULH   = 4'd1;
  localparam logic [3:0] OP_MULHSU = 4'd2;
  localparam logic [3:0] OP_MULHU  = 4'd3;
  localparam logic [3:0] OP_DIV    = 4'd4;
  localparam logic [3:0] OP_DIVU   = 4'd5;
  localparam logic [3:0] OP_REM    = 4'd6;
  localparam logic [3:0] OP_REMU   = 4'd7;
  localparam logic [3:0] OP_MULW   = 4'd8;
  localparam logic [3:0] OP_DIVW   = 4'd9;
  localparam logic [3:0] OP_DIVUW  = 4'd10;
  localparam logic [3:0] OP_REMW   = 4'd11;
  localparam logic [3:0] OP_REMUW  = 4'd12;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CW-1:0]       r_cnt;
  logic [3:0]          r_op;
  logic [2*XLEN-1:0]   r_work;
  logic [XLEN-1:0]     r_b;
  logic [XLEN-1:0]     r_res;
  logic                r_negQ;
  logic                r_negR;

  function automatic logic [XLEN-1:0] sextW(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  function automatic logic isWordOp(input logic [3:0] op);
    return op inside {OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
  endfunction

  function automatic logic isMulOp(input logic [3:0] op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_MULW};
  endfunction

  function automatic logic isRemOp(input logic [3:0] op);
    return op inside {OP_REM, OP_REMU, OP_REMW, OP_REMUW};
  endfunction

  logic            w_accept, w_inWord, w_inMul, w_inDiv, w_inRsv, w_inRem;
  logic            w_sgnA, w_sgnB, w_aNeg, w_bNeg, w_aMin;
  logic            w_divZero, w_ovf, w_mulZero, w_short;
  logic [XLEN-1:0] w_a, w_b, w_aMag, w_bMag, w_shortRaw, w_shortRes;

  assign w_accept = i_valid & o_in_ready & ~i_flush;
  assign w_inWord = isWordOp(i_op);
  assign w_inMul  = isMulOp(i_op);
  assign w_inRem  = isRemOp(i_op);
  assign w_inRsv  = (i_op > OP_REMUW);
  assign w_inDiv  = ~w_inMul & ~w_inRsv;
  assign w_sgnA   = i_op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM, OP_DIVW, OP_REMW};
  assign w_sgnB   = i_op inside {OP_MULH, OP_DIV, OP_REM, OP_DIVW, OP_REMW};

  assign w_a = w_inWord ? (w_sgnA ? sextW(i_src1[31:0]) : {{(XLEN-32){1'b0}}, i_src1[31:0]}) : i_src1;
  assign w_b = w_inWord ? (w_sgnB ? sextW(i_src2[31:0]) : {{(XLEN-32){1'b0}}, i_src2[31:0]}) : i_src2;

  assign w_aNeg = w_sgnA & w_a[XLEN-1];
  assign w_bNeg = w_sgnB & w_b[XLEN-1];
  assign w_aMag = w_aNeg ? -w_a : w_a;
  assign w_bMag = w_bNeg ? -w_b : w_b;

  assign w_aMin    = w_inWord ? (w_a == sextW(32'h8000_0000)) : (w_a == {1'b1, {(XLEN-1){1'b0}}});
  assign w_divZero = w_inDiv & (w_b == '0);
  assign w_ovf     = w_inDiv & w_sgnA & w_aMin & (w_b == '1);
`ifdef MDU_ZERO_SKIP_EN
  assign w_mulZero = w_inMul & ((w_a == '0) | (w_b == '0));
`else
  assign w_mulZero = 1'b0;
`endif
  assign w_short = w_inRsv | w_divZero | w_ovf | w_mulZero;

  // Results known at accept; reserved ops and zero-skip fall through to zero.
  always_comb begin
    w_shortRaw = '0;
    if (w_divZero) begin
      w_shortRaw = w_inRem ? w_a : '1;
    end else if (w_ovf) begin
      w_shortRaw = w_inRem ? '0 : w_a;
    end
  end
  assign w_shortRes = w_inWord ? sextW(w_shortRaw[31:0]) : w_shortRaw;

  logic [XLEN:0]     w_mulSum;
  logic [2*XLEN-1:0] w_mulStep, w_divStep;
  logic [XLEN:0]     w_divTop;
  logic [XLEN-1:0]   w_divDiff;
  logic              w_divGe;

  assign w_mulSum  = {1'b0, r_work[2*XLEN-1:XLEN]} + (r_work[0] ? {1'b0, r_b} : '0);
  assign w_mulStep = {w_mulSum, r_work[XLEN-1:1]};

  // The shifted remainder can need XLEN+1 bits when dividing by a large unsigned divisor.
  assign w_divTop  = r_work[2*XLEN-1:XLEN-1];
  assign w_divGe   = (w_divTop >= {1'b0, r_b});
  assign w_divDiff = w_divTop[XLEN-1:0] - r_b;
  assign w_divStep = w_divGe ? {w_divDiff, r_work[XLEN-2:0], 1'b1} : {r_work[2*XLEN-2:0], 1'b0};

  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo, w_rem, w_divRes, w_fixRes;

  assign w_prod   = r_negQ ? -r_work : r_work;
  assign w_quo    = r_negQ ? -r_work[XLEN-1:0] : r_work[XLEN-1:0];
  assign w_rem    = r_negR ? -r_work[2*XLEN-1:XLEN] : r_work[2*XLEN-1:XLEN];
  assign w_divRes = isRemOp(r_op) ? w_rem : w_quo;

  always_comb begin
    w_fixRes = isWordOp(r_op) ? sextW(w_divRes[31:0]) : w_divRes;
    case (r_op)
      OP_MUL:                        w_fixRes = w_prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  w_fixRes = w_prod[2*XLEN-1:XLEN];
      OP_MULW:                       w_fixRes = sextW(r_work[XLEN-1:HALF]);
      default: ;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = w_short ? S_DONE : S_CALC;
      S_CALC: begin
        if (i_flush)                  w_next = S_IDLE;
        else if (r_cnt == CW'(1))     w_next = S_FIX;
      end
      S_FIX:  w_next = i_flush ? S_IDLE : S_DONE;
      S_DONE: if (i_flush || i_out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Word divides sit in the top of the low half so 32 shifts bring the dividend into the remainder half.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_op   <= '0;
      r_work <= '0;
      r_b    <= '0;
      r_res  <= '0;
      r_negQ <= 1'b0;
      r_negR <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_op   <= i_op;
          r_negQ <= w_aNeg ^ w_bNeg;
          r_negR <= w_aNeg;
          r_cnt  <= w_inWord ? CW'(HALF) : CW'(XLEN);
          if (w_inMul) begin
            r_work <= {{XLEN{1'b0}}, w_bMag};
            r_b    <= w_aMag;
          end else begin
            r_work <= w_inWord ? {{XLEN{1'b0}}, w_aMag[HALF-1:0], {HALF{1'b0}}}
                               : {{XLEN{1'b0}}, w_aMag};
            r_b    <= w_bMag;
          end
          if (w_short) r_res <= w_shortRes;
        end
        S_CALC: if (!i_flush) begin
          r_work <= isMulOp(r_op) ? w_mulStep : w_divStep;
          r_cnt  <= r_cnt - CW'(1);
        end
        S_FIX: if (!i_flush) r_res <= w_fixRes;
        default: ;
      endcase
    end
  end

  assign o_in_ready = (r_state == S_IDLE);
  assign o_valid    = (r_state == S_DONE);
  assign o_busy     = (r_state != S_IDLE);
  assign o_res      = r_res;

endmodule

// File: doc/ysyx_22050078_mdu_seq.md
Name: ysyx_22050078_mdu_seq

Overview:
- Multi-cycle sequencer for the RV64M operations; replaces the single-cycle `*`, `/`, `%` paths in the execute stage.
- Accepts one op per handshake and runs an iterative radix-2 shift-add multiplier or shift-subtract divider on a shared 128-bit working register.
- Applies sign and special-case fixes, then holds the result until the consumer takes it.
- Sits beside the ALU; the pipeline stalls while `o_in_ready` is low.

Parameters:
- XLEN, 64, datapath width; word ops use the low 32 bits.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- i_valid  input  1  op request
- o_in_ready  output  1  sequencer can accept an op
- i_op  input  4  op code: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU, 8 MULW, 9 DIVW, 10 DIVUW, 11 REMW, 12 REMUW; 13-15 reserved
- i_src1  input  XLEN  rs1 operand
- i_src2  input  XLEN  rs2 operand
- i_flush  input  1  abort the current op
- o_valid  output  1  result available
- i_out_ready  input  1  consumer takes the result
- o_res  output  XLEN  result
- o_busy  output  1  state is not IDLE

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values: state=IDLE, o_valid=0, o_res=0, o_busy=0, o_in_ready=1, counter=0. Reset mid-operation discards the op immediately.
- States: IDLE, CALC, FIX, DONE.
- o_in_ready=1 only in IDLE.
- Accept: i_valid & o_in_ready at a rising edge. Latch the op and operand magnitudes and record the result sign.
- Signedness:
  - Signed operands: MULH (both), MULHSU (src1 only), DIV/REM and their W forms (both).
  - W ops use src[31:0], sign- or zero-extended per op.
- Special cases at accept, for DIV* and REM* only:
  - Divisor 0: quotient = all ones; remainder = dividend.
  - Signed overflow (most-negative / -1): quotient = dividend; remainder = 0.
  - Go IDLE→DONE directly; o_valid is high in the cycle after the accept edge.
- Normal path: IDLE→CALC for N cycles (N=64, or 32 for W ops), then FIX for 1 cycle, then DONE.
  - o_valid first rises N+2 cycles after the accept edge.
- Iteration step:
  - Multiply: add the multiplicand if multiplier LSB=1, then shift right.
  - Divide: shift left and trial-subtract; set the quotient bit if the result is non-negative.
  - Counter decrements each cycle; CALC exits when it reaches 0.
- FIX cycle:
  - Negate the quotient if the operand signs differ.
  - Negate the remainder if the dividend is negative.
  - Negate the 128-bit product if the signs differ.
  - Select the result: MUL → low 64 bits; MULH* → high 64 bits; W ops → sign-extend bit 31 of the 32-bit result, including DIVUW/REMUW.
- DONE:
  - o_valid=1 and o_res stays stable until i_out_ready.
  - On o_valid & i_out_ready, go to IDLE; a new op is accepted at the earliest one cycle later.
  - No same-cycle accept and drain.
- Flush:
  - i_flush in CALC, FIX or DONE → IDLE next cycle, o_valid=0, no result delivered.
  - i_flush in IDLE with i_valid → the op is not accepted.
  - Flush has priority over the DONE handshake.
- Reserved op codes: accepted, go straight to DONE with o_res=0.
- Inputs are sampled only at accept; later changes are ignored.

Optional Feature:
- Macro: MDU_ZERO_SKIP_EN.
- Defined: any multiply op with either operand zero goes IDLE→DONE with o_res=0, o_valid in the cycle after accept.
- Undefined: zero operands take the full N+2-cycle path; the result is the same.

Test Plan:
- MUL src1=7, src2=-3 (0xFFFF_FFFF_FFFF_FFFD), i_out_ready=1 → o_res=0xFFFF_FFFF_FFFF_FFEB; o_valid rises 66 cycles after accept; o_in_ready low throughout.
- MULHU both 0xFFFF_FFFF_FFFF_FFFF → 0xFFFF_FFFF_FFFF_FFFE. MULH src1=-1, src2=1 → 0xFFFF_FFFF_FFFF_FFFF.
- DIV src1=-7, src2=2 → -3; REM same operands → -1; DIVUW src1=0x8000_0000, src2=1 → 0xFFFF_FFFF_8000_0000; o_valid 34 cycles after accept.
- DIV src1=5, src2=0 → all ones; REMU src1=5, src2=0 → 5; DIV 0x8000_0000_0000_0000 / -1 → 0x8000_0000_0000_0000; each with o_valid one cycle after accept.
- Back-pressure: hold i_out_ready=0 for 10 cycles in DONE → o_res stable, o_in_ready=0. Assert i_flush at CALC cycle 20 → IDLE next cycle, no o_valid pulse, next op correct.
- Reset asserted during CALC → all outputs at reset values the next cycle. With MDU_ZERO_SKIP_EN defined, MUL src1=0, src2=9 → 0 in 1 cycle; undefined → 0 in 66 cycles.
